// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - 8N1 UART receiver with ready/valid byte output and error pulses
// Mid-bit sampling from a BAUD_CNT-clock timer; one-deep output register.
module uart_rx_ctrl #(
    parameter int unsigned BAUD_CNT = 416
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [15:0] HALF_LOAD = 16'(BAUD_CNT / 2 - 1);
    localparam logic [15:0] FULL_LOAD = 16'(BAUD_CNT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  sync_q;
    logic [2:0]  fill_q;
    logic        prev_q;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        frame_err_q;
    logic        overrun_q;
    logic        deliver;
    logic        ferr_d;
    logic        rx_s;
    logic        fall;
    logic        expiry;

    assign rx_s   = sync_q[2];
    assign expiry = (timer_q == 16'd0);
    // prev_q only reports a high once real line samples have filled the
    // synchronizer, so a line held low out of reset never looks like an edge.
    assign fall   = prev_q & ~rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b111;
            fill_q <= 3'b000;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], rx};
            fill_q <= {fill_q[1:0], 1'b1};
            prev_q <= fill_q[2] & rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        deliver = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    timer_d = HALF_LOAD;
                end
            end
            START: begin
                if (!expiry) begin
                    timer_d = timer_q - 16'd1;
                end else if (!rx_s) begin
                    state_d = DATA;
                    timer_d = FULL_LOAD;
                    bit_d   = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!expiry) begin
                    timer_d = timer_q - 16'd1;
                end else begin
                    shift_d = {rx_s, shift_q[7:1]};
                    timer_d = FULL_LOAD;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (!expiry) begin
                    timer_d = timer_q - 16'd1;
                end else if (rx_s) begin
                    state_d = IDLE;
                    deliver = 1'b1;
                end else begin
                    state_d = BREAK;
                    ferr_d  = 1'b1;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A delivery into a full, unaccepted register is dropped and flagged;
    // a simultaneous transfer frees the slot so the new byte lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= ferr_d;
            overrun_q   <= deliver & valid_q & ~ready;
            if (deliver && (!valid_q || ready)) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (valid_q && ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl at BAUD_CNT=8
module tb_uart_rx_ctrl;

    localparam int BAUD = 8;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    int n_valid     = 0;
    int n_ferr      = 0;
    int n_ovr       = 0;
    int busy_cycles = 0;
    int run_len     = 0;
    int last_run    = 0;
    logic v_prev    = 1'b0;
    logic [7:0] acc_q[$];

    int s_valid, s_ferr, s_ovr, s_busy, s_acc;

    uart_rx_ctrl #(.BAUD_CNT(BAUD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid && !v_prev) n_valid++;
        if (valid) begin
            run_len++;
        end else begin
            if (v_prev) last_run = run_len;
            run_len = 0;
        end
        v_prev = valid;
        if (valid && ready) acc_q.push_back(data);
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
        if (busy) busy_cycles++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        tick(BAUD);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        tick(n);
    endtask

    task automatic snap();
        s_valid = n_valid;
        s_ferr  = n_ferr;
        s_ovr   = n_ovr;
        s_busy  = busy_cycles;
        s_acc   = acc_q.size();
    endtask

    function automatic logic [7:0] last_acc();
        if (acc_q.size() == 0) return 8'hxx;
        return acc_q[acc_q.size() - 1];
    endfunction

    initial begin
        int t;
        int bad;
        logic [7:0] b;
        logic good;

        rx    = 1'b1;
        ready = 1'b1;
        rst_n = 1'b0;
        tick(3);
        check_eq("rst_data", 32'(data), 32'h00);
        check_eq("rst_valid", 32'(valid), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_frame_err", 32'(frame_err), 0);
        check_eq("rst_overrun", 32'(overrun), 0);

        // Line held low coming out of reset must not start a frame.
        rx = 1'b0;
        snap();
        rst_n = 1'b1;
        tick(40);
        check_eq("low_after_rst_busy", 32'(busy_cycles - s_busy), 0);
        idle(20);

        // Good frame, consumer always ready.
        snap();
        send_frame(8'hA5, 1'b1);
        idle(20);
        check_eq("a5_pulses", 32'(n_valid - s_valid), 1);
        check_eq("a5_pulse_width", 32'(last_run), 1);
        check_eq("a5_data", 32'(last_acc()), 32'hA5);
        check_eq("a5_ferr", 32'(n_ferr - s_ferr), 0);
        check_eq("a5_ovr", 32'(n_ovr - s_ovr), 0);

        // Back-pressure holds the byte stable.
        ready = 1'b0;
        snap();
        send_frame(8'h3C, 1'b1);
        rx = 1'b1;
        t = 0;
        while (!valid && t < 200) begin
            tick(1);
            t++;
        end
        check_eq("3c_valid_seen", 32'(valid), 1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (!(valid && data == 8'h3C)) bad++;
            tick(1);
        end
        check_eq("3c_stable_bad_cycles", 32'(bad), 0);
        ready = 1'b1;
        tick(1);
        check_eq("3c_valid_clear", 32'(valid), 0);
        check_eq("3c_accepted", 32'(last_acc()), 32'h3C);
        idle(10);

        // Second byte arrives while the first is still unconsumed.
        ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1);
        idle(4);
        send_frame(8'h22, 1'b1);
        idle(20);
        check_eq("ovr_pulses", 32'(n_ovr - s_ovr), 1);
        check_eq("ovr_data_kept", 32'(data), 32'h11);
        check_eq("ovr_valid", 32'(valid), 1);
        ready = 1'b1;
        tick(3);
        check_eq("ovr_drained", 32'(last_acc()), 32'h11);
        check_eq("ovr_drain_count", 32'(acc_q.size() - s_acc), 1);
        check_eq("ovr_valid_after", 32'(valid), 0);

        // Bad stop bit, line stays low afterwards.
        snap();
        send_frame(8'h55, 1'b0);
        tick(30);
        check_eq("ferr_busy_low", 32'(busy), 1);
        check_eq("ferr_pulses", 32'(n_ferr - s_ferr), 1);
        check_eq("ferr_no_valid", 32'(n_valid - s_valid), 0);
        idle(6);
        check_eq("ferr_busy_released", 32'(busy), 0);

        // Two-clock glitch on an idle line.
        snap();
        rx = 1'b0;
        tick(2);
        idle(30);
        check_eq("glitch_went_busy", 32'((busy_cycles - s_busy) > 0), 1);
        check_eq("glitch_busy_end", 32'(busy), 0);
        check_eq("glitch_no_valid", 32'(n_valid - s_valid), 0);
        check_eq("glitch_no_ferr", 32'(n_ferr - s_ferr), 0);

        // Reset during data bit 4 abandons the frame.
        snap();
        b = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        tick(3);
        rst_n = 1'b0;
        tick(2);
        check_eq("midrst_busy", 32'(busy), 0);
        rx = 1'b1;
        rst_n = 1'b1;
        idle(20);
        send_frame(8'hF0, 1'b1);
        idle(20);
        check_eq("midrst_pulses", 32'(n_valid - s_valid), 1);
        check_eq("midrst_data", 32'(last_acc()), 32'hF0);
        check_eq("midrst_ferr", 32'(n_ferr - s_ferr), 0);
        check_eq("midrst_ovr", 32'(n_ovr - s_ovr), 0);

        // Random frames: expected outcome follows directly from the stop bit.
        for (int k = 0; k < 24; k++) begin
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 5) != 0);
            snap();
            send_frame(b, good);
            if (!good) tick($urandom_range(0, 20));
            idle($urandom_range(5, 40));
            if (good) begin
                check_eq($sformatf("rnd%0d_pulses", k), 32'(n_valid - s_valid), 1);
                check_eq($sformatf("rnd%0d_data", k), 32'(last_acc()), 32'(b));
                check_eq($sformatf("rnd%0d_ferr", k), 32'(n_ferr - s_ferr), 0);
            end else begin
                check_eq($sformatf("rnd%0d_pulses", k), 32'(n_valid - s_valid), 0);
                check_eq($sformatf("rnd%0d_ferr", k), 32'(n_ferr - s_ferr), 1);
            end
            check_eq($sformatf("rnd%0d_ovr", k), 32'(n_ovr - s_ovr), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
